// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the five-stage control unit: opcodes, control bundle,
// forward-select encoding and the pipeline bubble.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       ru_wr;
        logic [3:0] alu_op;
        logic       alu_asrc;
        logic       alu_bsrc;
        logic       dm_rd;
        logic       dm_wr;
        logic [2:0] dm_ctrl;
        logic [4:0] br_op;
        logic [1:0] ru_data_wr_src;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational RV32I opcode/funct decoder producing the control bundle,
// immediate select, source-usage flags and a legal-opcode flag.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_b5,
    output ctrl_bundle_t ctrl,
    output logic [2:0]   imm_src,
    output logic         use_rs1,
    output logic         use_rs2,
    output logic         legal
);

    logic is_shift;
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        ctrl    = BUBBLE;
        imm_src = 3'b000;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        legal   = 1'b1;
        unique case (opcode)
            OP_R: begin
                ctrl.ru_wr  = 1'b1;
                ctrl.alu_op = {funct7_b5, funct3};
                use_rs2     = 1'b1;
            end
            OP_I: begin
                ctrl.ru_wr    = 1'b1;
                ctrl.alu_bsrc = 1'b1;
                ctrl.alu_op   = is_shift ? {funct7_b5, funct3} : {1'b0, funct3};
            end
            OP_LOAD: begin
                ctrl.ru_wr          = 1'b1;
                ctrl.alu_bsrc       = 1'b1;
                ctrl.dm_rd          = 1'b1;
                ctrl.dm_ctrl        = funct3;
                ctrl.ru_data_wr_src = 2'b01;
            end
            OP_STORE: begin
                ctrl.alu_bsrc = 1'b1;
                ctrl.dm_wr    = 1'b1;
                ctrl.dm_ctrl  = funct3;
                imm_src       = 3'b001;
                use_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_asrc = 1'b1;
                ctrl.alu_bsrc = 1'b1;
                ctrl.br_op    = {2'b01, funct3};
                imm_src       = 3'b101;
                use_rs2       = 1'b1;
            end
            OP_JAL: begin
                ctrl.ru_wr          = 1'b1;
                ctrl.alu_asrc       = 1'b1;
                ctrl.alu_bsrc       = 1'b1;
                ctrl.br_op          = 5'b10000;
                ctrl.ru_data_wr_src = 2'b10;
                imm_src             = 3'b110;
                use_rs1             = 1'b0;
            end
            OP_JALR: begin
                ctrl.ru_wr          = 1'b1;
                ctrl.alu_bsrc       = 1'b1;
                ctrl.br_op          = 5'b10000;
                ctrl.ru_data_wr_src = 2'b10;
            end
            OP_LUI: begin
                ctrl.ru_wr    = 1'b1;
                ctrl.alu_bsrc = 1'b1;
                ctrl.alu_op   = 4'b0111;
                imm_src       = 3'b010;
                use_rs1       = 1'b0;
            end
            OP_AUIPC: begin
                ctrl.ru_wr    = 1'b1;
                ctrl.alu_asrc = 1'b1;
                ctrl.alu_bsrc = 1'b1;
                imm_src       = 3'b010;
                use_rs1       = 1'b0;
            end
            default: begin
                legal   = 1'b0;
                use_rs1 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Five-stage control pipeline with hazard detection, flush and stall count.
// Define PIPE_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module pipelined_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int INSTR_W    = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    instr_id,
    input  logic                  instr_valid_id,
    input  logic                  br_taken_ex,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic [2:0]            imm_src_id,
    output logic                  ru_wr_ex,
    output logic                  alu_asrc_ex,
    output logic                  alu_bsrc_ex,
    output logic                  dm_rd_ex,
    output logic [3:0]            alu_op_ex,
    output logic [4:0]            br_op_ex,
    output logic                  dm_wr_mem,
    output logic [2:0]            dm_ctrl_mem,
    output logic                  ru_wr_wb,
    output logic [1:0]            ru_data_wr_src_wb,
    output logic [REG_ADDR_W-1:0] rd_wb,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  illegal_instr,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef logic [REG_ADDR_W-1:0] reg_t;

    ctrl_bundle_t dec_ctrl;
    logic [2:0]   dec_imm;
    logic         dec_use1, dec_use2, dec_legal;
    reg_t         rs1_id, rs2_id;
    logic         hazard, stall, accept;
    logic         unused_bits;

    ctrl_bundle_t ex_ctrl_q, ex_ctrl_d;
    reg_t         ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic         mem_ru_wr_q, mem_ru_wr_d, mem_dm_wr_q, mem_dm_wr_d;
    logic [2:0]   mem_dm_ctrl_q, mem_dm_ctrl_d;
    logic [1:0]   mem_wb_src_q, mem_wb_src_d;
    reg_t         mem_rd_q, mem_rd_d;
    logic         wb_ru_wr_q, wb_ru_wr_d;
    logic [1:0]   wb_wb_src_q, wb_wb_src_d;
    reg_t         wb_rd_q, wb_rd_d;
    logic         illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fwd_sel_t     fwd_a, fwd_b;

    ctrl_decoder u_dec (
        .opcode    (instr_id[6:0]),
        .funct3    (instr_id[14:12]),
        .funct7_b5 (instr_id[30]),
        .ctrl      (dec_ctrl),
        .imm_src   (dec_imm),
        .use_rs1   (dec_use1),
        .use_rs2   (dec_use2),
        .legal     (dec_legal)
    );

    assign unused_bits = ^{instr_id[INSTR_W-1:31], instr_id[29:25]};

    // Unused sources are zeroed so they can never match a non-zero rd.
    assign rs1_id = dec_use1 ? instr_id[15 +: REG_ADDR_W] : '0;
    assign rs2_id = dec_use2 ? instr_id[20 +: REG_ADDR_W] : '0;

    function automatic logic hit(logic wr, reg_t rd, reg_t rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

    logic uses_ex, uses_mem;
    assign uses_ex  = hit(ex_ctrl_q.ru_wr, ex_rd_q, rs1_id) ||
                      hit(ex_ctrl_q.ru_wr, ex_rd_q, rs2_id);
    assign uses_mem = hit(mem_ru_wr_q, mem_rd_q, rs1_id) ||
                      hit(mem_ru_wr_q, mem_rd_q, rs2_id);

`ifdef PIPE_FORWARDING_EN
    assign hazard = instr_valid_id && ex_ctrl_q.dm_rd && uses_ex;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (hit(mem_ru_wr_q, mem_rd_q, ex_rs1_q))
            fwd_a = FWD_EXMEM;
        else if (hit(wb_ru_wr_q, wb_rd_q, ex_rs1_q))
            fwd_a = FWD_MEMWB;
        if (hit(mem_ru_wr_q, mem_rd_q, ex_rs2_q))
            fwd_b = FWD_EXMEM;
        else if (hit(wb_ru_wr_q, wb_rd_q, ex_rs2_q))
            fwd_b = FWD_MEMWB;
    end
`else
    logic unused_rs;
    assign unused_rs = ^{ex_rs1_q, ex_rs2_q};
    assign hazard    = instr_valid_id && (uses_ex || uses_mem);
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
`endif

    // Flush wins over stall.
    assign stall  = hazard && !br_taken_ex;
    assign accept = instr_valid_id && !stall && !br_taken_ex;

    always_comb begin
        ex_ctrl_d     = accept ? dec_ctrl : BUBBLE;
        ex_rd_d       = (accept && dec_ctrl.ru_wr) ? instr_id[7 +: REG_ADDR_W] : '0;
        ex_rs1_d      = accept ? rs1_id : '0;
        ex_rs2_d      = accept ? rs2_id : '0;
        mem_ru_wr_d   = ex_ctrl_q.ru_wr;
        mem_dm_wr_d   = ex_ctrl_q.dm_wr;
        mem_dm_ctrl_d = ex_ctrl_q.dm_ctrl;
        mem_wb_src_d  = ex_ctrl_q.ru_data_wr_src;
        mem_rd_d      = ex_rd_q;
        wb_ru_wr_d    = mem_ru_wr_q;
        wb_wb_src_d   = mem_wb_src_q;
        wb_rd_d       = mem_rd_q;
        illegal_d     = illegal_q || (accept && !dec_legal);
        cnt_d         = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl_q     <= BUBBLE;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            mem_ru_wr_q   <= 1'b0;
            mem_dm_wr_q   <= 1'b0;
            mem_dm_ctrl_q <= '0;
            mem_wb_src_q  <= '0;
            mem_rd_q      <= '0;
            wb_ru_wr_q    <= 1'b0;
            wb_wb_src_q   <= '0;
            wb_rd_q       <= '0;
            illegal_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            mem_ru_wr_q   <= mem_ru_wr_d;
            mem_dm_wr_q   <= mem_dm_wr_d;
            mem_dm_ctrl_q <= mem_dm_ctrl_d;
            mem_wb_src_q  <= mem_wb_src_d;
            mem_rd_q      <= mem_rd_d;
            wb_ru_wr_q    <= wb_ru_wr_d;
            wb_wb_src_q   <= wb_wb_src_d;
            wb_rd_q       <= wb_rd_d;
            illegal_q     <= illegal_d;
            cnt_q         <= cnt_d;
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign stall_if          = stall && !rst;
    assign stall_id          = stall && !rst;
    assign flush_id          = br_taken_ex && !rst;
    assign imm_src_id        = rst ? 3'b000 : dec_imm;
    assign ru_wr_ex          = ex_ctrl_q.ru_wr;
    assign alu_asrc_ex       = ex_ctrl_q.alu_asrc;
    assign alu_bsrc_ex       = ex_ctrl_q.alu_bsrc;
    assign dm_rd_ex          = ex_ctrl_q.dm_rd;
    assign alu_op_ex         = ex_ctrl_q.alu_op;
    assign br_op_ex          = ex_ctrl_q.br_op;
    assign dm_wr_mem         = mem_dm_wr_q;
    assign dm_ctrl_mem       = mem_dm_ctrl_q;
    assign ru_wr_wb          = wb_ru_wr_q;
    assign ru_data_wr_src_wb = wb_wb_src_q;
    assign rd_wb             = wb_rd_q;
    assign fwd_a_sel         = fwd_a;
    assign fwd_b_sel         = fwd_b;
    assign illegal_instr     = illegal_q;
    assign stall_cnt         = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: a cycle-level instruction-window model predicts every
// output; a negedge monitor pops and compares.
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_id = '0;
    logic        instr_valid_id = 1'b0;
    logic        br_taken_ex = 1'b0;
    logic        stall_if, stall_id, flush_id;
    logic [2:0]  imm_src_id;
    logic        ru_wr_ex, alu_asrc_ex, alu_bsrc_ex, dm_rd_ex;
    logic [3:0]  alu_op_ex;
    logic [4:0]  br_op_ex;
    logic        dm_wr_mem;
    logic [2:0]  dm_ctrl_mem;
    logic        ru_wr_wb;
    logic [1:0]  ru_data_wr_src_wb;
    logic [4:0]  rd_wb;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        illegal_instr;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .instr_id(instr_id),
        .instr_valid_id(instr_valid_id), .br_taken_ex(br_taken_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .imm_src_id(imm_src_id), .ru_wr_ex(ru_wr_ex),
        .alu_asrc_ex(alu_asrc_ex), .alu_bsrc_ex(alu_bsrc_ex),
        .dm_rd_ex(dm_rd_ex), .alu_op_ex(alu_op_ex), .br_op_ex(br_op_ex),
        .dm_wr_mem(dm_wr_mem), .dm_ctrl_mem(dm_ctrl_mem),
        .ru_wr_wb(ru_wr_wb), .ru_data_wr_src_wb(ru_data_wr_src_wb),
        .rd_wb(rd_wb), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .illegal_instr(illegal_instr), .stall_cnt(stall_cnt)
    );

    localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, ST = 7'h23;
    localparam logic [6:0] BR = 7'h63, JAL = 7'h6f, JALR = 7'h67;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17;

    // One in-flight instruction as seen by later stages.
    typedef struct packed {
        logic       ru_wr;
        logic [3:0] alu_op;
        logic       asrc, bsrc, dm_rd, dm_wr;
        logic [2:0] dm_ctrl;
        logic [4:0] br_op;
        logic [1:0] wbsrc;
        logic [4:0] rd, rs1, rs2;
    } rec_t;

    typedef struct packed {
        logic       stall, flush;
        logic [2:0] imm;
        logic       ru_wr_ex, asrc_ex, bsrc_ex, dm_rd_ex;
        logic [3:0] alu_op_ex;
        logic [4:0] br_op_ex;
        logic       dm_wr_mem;
        logic [2:0] dm_ctrl_mem;
        logic       ru_wr_wb;
        logic [1:0] wbsrc_wb;
        logic [4:0] rd_wb;
        logic [1:0] fa, fb;
        logic       ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    rec_t ex_m = '0, mem_m = '0, wb_m = '0;
    logic ill_m = 1'b0;
    int   cnt_m = 0;

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd,
        input int rs1, input int rs2, input logic [2:0] f3, input logic b30);
        logic [31:0] w;
        w = {1'b0, b30, 5'b0, rs2[4:0], rs1[4:0], f3, rd[4:0], op};
        return w;
    endfunction

    function automatic void decode(input logic [31:0] w, output rec_t r,
                                   output logic [2:0] imm, output logic legal);
        logic [2:0] f3;
        logic       u1, u2;
        f3 = w[14:12];
        r = '0; imm = 3'd0; legal = 1'b1; u1 = 1'b1; u2 = 1'b0;
        case (w[6:0])
            R: begin r.ru_wr = 1; r.alu_op = {w[30], f3}; u2 = 1; end
            I: begin
                r.ru_wr = 1; r.bsrc = 1;
                r.alu_op = (f3 == 3'd1 || f3 == 3'd5) ? {w[30], f3} : {1'b0, f3};
            end
            LD: begin
                r.ru_wr = 1; r.bsrc = 1; r.dm_rd = 1; r.dm_ctrl = f3; r.wbsrc = 2'b01;
            end
            ST: begin r.bsrc = 1; r.dm_wr = 1; r.dm_ctrl = f3; imm = 3'b001; u2 = 1; end
            BR: begin
                r.asrc = 1; r.bsrc = 1; r.br_op = {2'b01, f3}; imm = 3'b101; u2 = 1;
            end
            JAL: begin
                r.ru_wr = 1; r.asrc = 1; r.bsrc = 1; r.br_op = 5'b10000;
                r.wbsrc = 2'b10; imm = 3'b110; u1 = 0;
            end
            JALR: begin r.ru_wr = 1; r.bsrc = 1; r.br_op = 5'b10000; r.wbsrc = 2'b10; end
            LUI: begin r.ru_wr = 1; r.bsrc = 1; r.alu_op = 4'b0111; imm = 3'b010; u1 = 0; end
            AUIPC: begin r.ru_wr = 1; r.asrc = 1; r.bsrc = 1; imm = 3'b010; u1 = 0; end
            default: begin legal = 0; u1 = 0; end
        endcase
        if (r.ru_wr) r.rd = w[11:7];
        if (u1) r.rs1 = w[19:15];
        if (u2) r.rs2 = w[24:20];
    endfunction

    function automatic logic writes(input rec_t p, input logic [4:0] rs);
        return p.ru_wr && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic logic [1:0] src(input logic [4:0] rs);
        if (writes(mem_m, rs)) return 2'b01;
        if (writes(wb_m, rs)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input logic [31:0] w, input logic v, input logic br,
                        input logic r, output logic stalled);
        exp_t e;
        rec_t d, nx;
        logic [2:0] imm;
        logic legal, haz, u_ex, u_mem;
        instr_id = w; instr_valid_id = v; br_taken_ex = br; rst = r;
        decode(w, d, imm, legal);
        e = '0; stalled = 1'b0; nx = '0;
        if (!r) begin
            u_ex  = writes(ex_m, d.rs1) || writes(ex_m, d.rs2);
            u_mem = writes(mem_m, d.rs1) || writes(mem_m, d.rs2);
`ifdef PIPE_FORWARDING_EN
            haz = v && ex_m.dm_rd && u_ex;
            e.fa = src(ex_m.rs1);
            e.fb = src(ex_m.rs2);
`else
            haz = v && (u_ex || u_mem);
`endif
            stalled = haz && !br;
            e.stall = stalled; e.flush = br; e.imm = imm;
            e.ru_wr_ex = ex_m.ru_wr; e.asrc_ex = ex_m.asrc;
            e.bsrc_ex = ex_m.bsrc; e.dm_rd_ex = ex_m.dm_rd;
            e.alu_op_ex = ex_m.alu_op; e.br_op_ex = ex_m.br_op;
            e.dm_wr_mem = mem_m.dm_wr; e.dm_ctrl_mem = mem_m.dm_ctrl;
            e.ru_wr_wb = wb_m.ru_wr; e.wbsrc_wb = wb_m.wbsrc; e.rd_wb = wb_m.rd;
            e.ill = ill_m; e.cnt = cnt_m[15:0];
            if (v && !stalled && !br) nx = d;
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            ex_m = '0; mem_m = '0; wb_m = '0; ill_m = 0; cnt_m = 0;
        end else begin
            if (v && !legal && !stalled && !br) ill_m = 1'b1;
            if (stalled && cnt_m < 65535) cnt_m++;
            wb_m = mem_m; mem_m = ex_m; ex_m = nx;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("stall_if", stall_if, e.stall);
                chk("stall_id", stall_id, e.stall);
                chk("flush_id", flush_id, e.flush);
                chk("imm_src_id", imm_src_id, e.imm);
                chk("ru_wr_ex", ru_wr_ex, e.ru_wr_ex);
                chk("alu_asrc_ex", alu_asrc_ex, e.asrc_ex);
                chk("alu_bsrc_ex", alu_bsrc_ex, e.bsrc_ex);
                chk("dm_rd_ex", dm_rd_ex, e.dm_rd_ex);
                chk("alu_op_ex", alu_op_ex, e.alu_op_ex);
                chk("br_op_ex", br_op_ex, e.br_op_ex);
                chk("dm_wr_mem", dm_wr_mem, e.dm_wr_mem);
                chk("dm_ctrl_mem", dm_ctrl_mem, e.dm_ctrl_mem);
                chk("ru_wr_wb", ru_wr_wb, e.ru_wr_wb);
                chk("ru_data_wr_src_wb", ru_data_wr_src_wb, e.wbsrc_wb);
                chk("rd_wb", rd_wb, e.rd_wb);
                chk("fwd_a_sel", fwd_a_sel, e.fa);
                chk("fwd_b_sel", fwd_b_sel, e.fb);
                chk("illegal_instr", illegal_instr, e.ill);
                chk("stall_cnt", stall_cnt, e.cnt);
            end
        end
    end

    function automatic logic [31:0] rnd_instr();
        int regs[5] = '{0, 1, 5, 6, 7};
        int rd, a, b, k;
        logic [2:0] f3;
        logic [6:0] ops[10] = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC, 7'h00};
        rd = regs[$urandom_range(4)];
        a  = regs[$urandom_range(4)];
        b  = regs[$urandom_range(4)];
        f3 = 3'($urandom_range(7));
        k  = ($urandom_range(99) < 3) ? 9 : $urandom_range(8);
        return mk(ops[k], rd, a, b, f3, 1'($urandom_range(1)));
    endfunction

    typedef struct packed {
        logic [31:0] w;
        logic v, br, r;
    } ent_t;

    initial begin : driver
        ent_t prog[$];
        logic st;
        int guard;
        logic [31:0] nop;
        nop = mk(I, 0, 0, 0, 3'd0, 1'b0);
        prog.push_back('{nop, 1'b0, 1'b0, 1'b1});
        prog.push_back('{nop, 1'b0, 1'b0, 1'b1});
        prog.push_back('{mk(LD, 5, 1, 0, 3'b010, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(R, 6, 5, 1, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(R, 5, 1, 2, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(R, 7, 5, 5, 3'd0, 1), 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(LD, 5, 1, 0, 3'b010, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(R, 6, 5, 1, 3'd0, 0), 1'b1, 1'b1, 1'b0});
        prog.push_back('{mk(AUIPC, 3, 0, 0, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(LUI, 0, 0, 0, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(R, 1, 0, 0, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{32'h0, 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(R, 2, 1, 1, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b0});
        prog.push_back('{mk(LD, 5, 1, 0, 3'b000, 0), 1'b1, 1'b0, 1'b0});
        prog.push_back('{nop, 1'b1, 1'b0, 1'b1});
        prog.push_back('{mk(R, 8, 1, 2, 3'd0, 0), 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) prog.push_back('{nop, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 400; i++)
            prog.push_back('{rnd_instr(), 1'($urandom_range(99) < 90),
                             1'($urandom_range(99) < 8),
                             1'($urandom_range(199) == 0)});
        @(posedge clk);
        #1;
        foreach (prog[i]) begin
            guard = 0;
            do begin
                step(prog[i].w, prog[i].v, prog[i].br, prog[i].r, st);
                guard++;
            end while (st && guard < 8);
        end
        step(nop, 1'b0, 1'b0, 1'b0, st);
        repeat (3) @(negedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Five-stage successor to the single-cycle control decoder.
- Decodes the RV32I instruction held in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use and RAW hazards, stalls IF/ID, and flushes on taken branches and jumps.
- Adds AUIPC decode, a sticky illegal-opcode flag and a saturating stall counter.

Parameters:
- REG_ADDR_W, 5, register-address width (rd/rs1/rs2).
- INSTR_W, 32, instruction width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- instr_id  in  INSTR_W  instruction in ID stage
- instr_valid_id  in  1  instr_id is a real instruction
- br_taken_ex  in  1  branch unit: redirect taken by the instruction in EX
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_id  out  1  clear IF/ID register
- imm_src_id  out  3  immediate select for ID-stage immediate generator
- ru_wr_ex, alu_asrc_ex, alu_bsrc_ex, dm_rd_ex  out  1 each  EX-stage controls
- alu_op_ex  out  4  ALU operation
- br_op_ex  out  5  branch operation
- dm_wr_mem  out  1  data-memory write enable
- dm_ctrl_mem  out  3  data-memory access size/sign control
- ru_wr_wb  out  1  register-file write enable
- ru_data_wr_src_wb  out  2  write-back source select
- rd_wb  out  REG_ADDR_W  write-back destination register
- fwd_a_sel, fwd_b_sel  out  2 each  ALU operand forward select
- illegal_instr  out  1  sticky illegal-opcode flag
- stall_cnt  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset: all pipeline registers load a bubble (every enable 0, all fields 0). All outputs are 0. Reset mid-operation discards in-flight instructions immediately.
- Decode is combinational in ID and uses the team control encoding:
  - R-type: ALUOp={f7[5],f3}.
  - I-ALU: ALUOp={f7[5],f3} for shifts (f3=001/101), else {0,f3}.
  - Load: add, DMRd=1, RUDataWrSrc=01.
  - Store: ImmSrc=001.
  - Branch: ImmSrc=101, BrOp={01,f3}.
  - JAL: ImmSrc=110, BrOp=10000, ALUASrc=1, RUDataWrSrc=10.
  - JALR: BrOp=10000, RUDataWrSrc=10.
  - LUI: ALUOp=0111, ImmSrc=010.
  - AUIPC (0010111), new: RUWr=1, ALUASrc=1, ALUBSrc=1, ImmSrc=010, ALUOp=0000, RUDataWrSrc=00.
  - Any other opcode: all-zero bundle.
- Source usage:
  - rs1 is used by everything except LUI, AUIPC and JAL.
  - rs2 is used by R-type, store and branch.
  - rd=x0 never creates a hazard.
- Load-use hazard: EX holds a load (dm_rd_ex=1, rd_ex≠0), and rd_ex equals a used rs of the valid ID instruction.
  - stall_if=stall_id=1 for exactly one cycle.
  - A bubble is loaded into ID/EX.
- Flush: br_taken_ex=1 gives flush_id=1 and a bubble into ID/EX in the same cycle.
  - Flush has priority over stall; stall_if/stall_id=0 that cycle.
- ID/EX loads a bubble when: stall, flush, or instr_valid_id=0. Otherwise it loads the decoded bundle plus rd/rs1/rs2.
- EX/MEM and MEM/WB advance every cycle; there is no back-pressure.
- Latency: decoded fields appear at EX outputs 1 cycle after ID, MEM at 2, WB at 3.
- The register file is write-first, so a WB-to-ID hazard is not a hazard.
- illegal_instr:
  - Set at the clock edge when a valid ID instruction with an unknown opcode is accepted (not stalled, not flushed).
  - Cleared only by rst.
  - The illegal instruction proceeds as a bubble.
- stall_cnt increments on every cycle with stall_if=1 and saturates at all-ones.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- Defined:
  - EX/MEM→EX and MEM/WB→EX forwarding is enabled.
  - fwd_x_sel: 00 = register file, 01 = EX/MEM, 10 = MEM/WB. EX/MEM has priority; never from rd=x0.
  - Only load-use hazards stall.
- Undefined:
  - fwd_a_sel/fwd_b_sel are tied to 00.
  - Any used rs matching a writing rd in EX or MEM stalls, one cycle per cycle the match persists.

Decomposition:
- Package pipe_ctrl_pkg:
  - Opcode localparams.
  - fwd_sel_t enum.
  - ctrl_bundle_t packed struct (RUWr, ALUOp, ALUASrc, ALUBSrc, DMRd, DMWr, DMCtrl, BrOp, RUDataWrSrc).
  - BUBBLE constant.
- Sub-module ctrl_decoder: pure combinational opcode/funct → ctrl_bundle_t, imm_src and rs-usage flags.

Test Plan:
- Reset asserted mid-stream with a load in EX → all outputs 0 asynchronously; stall_cnt=0; next valid ADD reaches ru_wr_wb=1 three cycles after entering ID.
- LW x5 followed by ADD x6,x5,x1 → one stall cycle (stall_if=1), bubble in EX, stall_cnt=1. With forwarding, fwd_a_sel=10 when the ADD is in EX.
- ADD x5 followed by SUB x7,x5,x5, with PIPE_FORWARDING_EN → no stall, fwd_a_sel=fwd_b_sel=01. Without the macro → two stall cycles.
- br_taken_ex=1 coinciding with a load-use condition → flush_id=1, stall_if=0, bubble in ID/EX, stall_cnt unchanged.
- Opcode 0000000 valid in ID → illegal_instr=1 next cycle and held through later legal instructions until rst; no write in WB.
- AUIPC x3 → alu_asrc_ex=1, alu_bsrc_ex=1, imm_src_id=010; LUI x0 followed by a use of x0 → no stall, fwd_sel=00.
